// File: rtl/sat_sub.sv
// Registered saturating subtractor: out = clamp(clamp(acc) - clamp(arg1), -LIMIT, +LIMIT), one-cycle latency.
// Optional sticky overflow flag with clear input is enabled by defining SAT_SUB_STICKY_OVF_EN.
module sat_sub #(
    parameter int WIDTH = 11,
    parameter int LIMIT = 999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] arg1,
`ifdef SAT_SUB_STICKY_OVF_EN
    input  logic             ovf_clr,
    output logic             ovf_sticky,
`endif
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             ovf_pos,
    output logic             ovf_neg,
    output logic             zero,
    output logic             neg
);

    // One extra bit of headroom so the difference of two clamped operands never wraps.
    localparam logic signed [WIDTH:0] LIM_P = (WIDTH+1)'(LIMIT);
    localparam logic signed [WIDTH:0] LIM_N = -LIM_P;

    logic signed [WIDTH:0] acc_x, arg_x, acc_c, arg_c, diff, sat;
    logic                  sat_pos, sat_neg;

    logic [WIDTH-1:0] out_d, out_q;
    logic             out_valid_d, out_valid_q;
    logic             ovf_pos_d, ovf_pos_q;
    logic             ovf_neg_d, ovf_neg_q;
    logic             zero_d, zero_q;
    logic             neg_d, neg_q;

    always_comb begin
        acc_x = $signed({acc[WIDTH-1], acc});
        arg_x = $signed({arg1[WIDTH-1], arg1});

        if (acc_x > LIM_P)      acc_c = LIM_P;
        else if (acc_x < LIM_N) acc_c = LIM_N;
        else                    acc_c = acc_x;

        if (arg_x > LIM_P)      arg_c = LIM_P;
        else if (arg_x < LIM_N) arg_c = LIM_N;
        else                    arg_c = arg_x;

        diff    = acc_c - arg_c;
        sat_pos = (diff > LIM_P);
        sat_neg = (diff < LIM_N);

        if (sat_pos)      sat = LIM_P;
        else if (sat_neg) sat = LIM_N;
        else              sat = diff;
    end

    always_comb begin
        out_d       = out_q;
        ovf_pos_d   = ovf_pos_q;
        ovf_neg_d   = ovf_neg_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out_d     = sat[WIDTH-1:0];
            ovf_pos_d = sat_pos;
            ovf_neg_d = sat_neg;
            zero_d    = (sat == '0);
            neg_d     = sat[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_pos_q   <= 1'b0;
            ovf_neg_q   <= 1'b0;
            zero_q      <= 1'b1;
            neg_q       <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_pos_q   <= ovf_pos_d;
            ovf_neg_q   <= ovf_neg_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign ovf_pos   = ovf_pos_q;
    assign ovf_neg   = ovf_neg_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

`ifdef SAT_SUB_STICKY_OVF_EN
    logic ovf_sticky_d, ovf_sticky_q;

    // A fresh overflow beats a simultaneous clear.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        if (ovf_clr)
            ovf_sticky_d = 1'b0;
        if (in_valid && (sat_pos || sat_neg))
            ovf_sticky_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_sticky_q <= 1'b0;
        else
            ovf_sticky_q <= ovf_sticky_d;
    end

    assign ovf_sticky = ovf_sticky_q;
`endif

endmodule

// File: tb/tb_sat_sub.sv
// Randomized self-checking bench for sat_sub against an integer reference model.
// Sticky-flag checks are included when SAT_SUB_STICKY_OVF_EN is defined.
module tb_sat_sub;

    localparam int WIDTH = 11;
    localparam int LIMIT = 999;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] arg1;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             ovf_pos;
    logic             ovf_neg;
    logic             zero;
    logic             neg;
`ifdef SAT_SUB_STICKY_OVF_EN
    logic             ovf_clr;
    logic             ovf_sticky;
`endif

    sat_sub #(.WIDTH(WIDTH), .LIMIT(LIMIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .acc       (acc),
        .arg1      (arg1),
`ifdef SAT_SUB_STICKY_OVF_EN
        .ovf_clr   (ovf_clr),
        .ovf_sticky(ovf_sticky),
`endif
        .out       (out),
        .out_valid (out_valid),
        .ovf_pos   (ovf_pos),
        .ovf_neg   (ovf_neg),
        .zero      (zero),
        .neg       (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: what the outputs should show right now.
    int exp_out    = 0;
    int exp_valid  = 0;
    int exp_pos    = 0;
    int exp_neg    = 0;
    int exp_sticky = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int clampl(input int x);
        if (x > LIMIT)  return LIMIT;
        if (x < -LIMIT) return -LIMIT;
        return x;
    endfunction

    task automatic check_all(input string tag);
        int o;
        o = $signed(out);
        check({tag, ".out"},       o,         exp_out);
        check({tag, ".out_valid"}, int'(out_valid), exp_valid);
        check({tag, ".ovf_pos"},   int'(ovf_pos),   exp_pos);
        check({tag, ".ovf_neg"},   int'(ovf_neg),   exp_neg);
        check({tag, ".zero"},      int'(zero),      int'(exp_out == 0));
        check({tag, ".neg"},       int'(neg),       int'(exp_out < 0));
`ifdef SAT_SUB_STICKY_OVF_EN
        check({tag, ".sticky"},    int'(ovf_sticky), exp_sticky);
`endif
    endtask

    task automatic model_reset();
        exp_out = 0; exp_valid = 0; exp_pos = 0; exp_neg = 0; exp_sticky = 0;
    endtask

    // Called at a negedge: drive, take one rising edge, check at the next negedge.
    task automatic step(input string tag, input int a, input int b, input bit v, input bit clr);
        int d;
        acc      = a[WIDTH-1:0];
        arg1     = b[WIDTH-1:0];
        in_valid = v;
`ifdef SAT_SUB_STICKY_OVF_EN
        ovf_clr  = clr;
`endif
        @(posedge clk);
        exp_valid = int'(v);
        if (clr) exp_sticky = 0;
        if (v) begin
            d       = clampl(a) - clampl(b);
            exp_out = clampl(d);
            exp_pos = int'(d > LIMIT);
            exp_neg = int'(d < -LIMIT);
            if (d > LIMIT || d < -LIMIT) exp_sticky = 1;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        int a, b;
        bit v;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        acc      = '0;
        arg1     = '0;
`ifdef SAT_SUB_STICKY_OVF_EN
        ovf_clr  = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        step("n_neg",   -51,   51, 1'b1, 1'b0);
        step("n_pos",    52,  -53, 1'b1, 1'b0);
        step("mix1",    -25,  -27, 1'b1, 1'b0);
        step("mix2",     27,   25, 1'b1, 1'b0);
        step("sat_neg", -951,  902, 1'b1, 1'b0);
        step("bnd_neg", -500,  499, 1'b1, 1'b0);
        step("bnd_pos",  500, -499, 1'b1, 1'b0);
        step("sat_pos",  900, -900, 1'b1, 1'b0);
        step("ood",     1023, -1024, 1'b1, 1'b0);
        step("ood_clmp", 1000, 1, 1'b1, 1'b0);
        step("zero",       7,    7, 1'b1, 1'b0);
        repeat (3) step("hold0", 5, -3, 1'b0, 1'b0);
        step("pre_rst", 900, -900, 1'b1, 1'b0);

        // Asynchronous reset between edges must clear outputs immediately.
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        acc = 11'd100; arg1 = 11'd3; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all("rst_held");
        rst_n = 1'b1;
        step("post_rst", 100, 3, 1'b1, 1'b0);
        step("held1", -800, 400, 1'b1, 1'b0);
        step("hold1", 0, 0, 1'b0, 1'b0);

`ifdef SAT_SUB_STICKY_OVF_EN
        step("st_set",  900, -900, 1'b1, 1'b0);
        step("st_keep",   1,    1, 1'b1, 1'b0);
        step("st_clr",    1,    1, 1'b0, 1'b1);
        step("st_win",  900, -900, 1'b1, 1'b1);
`endif

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom_range(0, 2047) - 1024;
                b = $urandom_range(0, 2047) - 1024;
            end else begin
                a = $urandom_range(0, 2 * LIMIT) - LIMIT;
                b = $urandom_range(0, 2 * LIMIT) - LIMIT;
            end
            v = ($urandom_range(0, 4) != 0);
            step("rand", a, b, v, ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
